// File: rtl/ahb_mux_param_if.sv
// Bus bundle between the single AHB-lite master, the slave mux and its slaves.
// The mux attaches through the slave modport; the master side uses the master modport.
interface ahb_mux_param_if #(
    parameter int NSLAVES = 7,
    parameter int SELW    = 3,
    parameter int DW      = 32
);
    logic [SELW-1:0]       M_SEL_I;
    logic [1:0]            M_HTRANS_I;
    logic                  M_HREADY_I;
    logic                  M_HREADY_O;
    logic                  M_HRESP_O;
    logic [DW-1:0]         M_HRDATA_O;
    logic [NSLAVES-1:0]    S_SEL_O;
    logic [NSLAVES-1:0]    S_HREADY_I;
    logic [NSLAVES-1:0]    S_HRESP_I;
    logic [NSLAVES*DW-1:0] S_HRDATA_I;

    modport slave (
        input  M_SEL_I, M_HTRANS_I, M_HREADY_I, S_HREADY_I, S_HRESP_I, S_HRDATA_I,
        output M_HREADY_O, M_HRESP_O, M_HRDATA_O, S_SEL_O
    );

    modport master (
        output M_SEL_I, M_HTRANS_I, M_HREADY_I, S_HREADY_I, S_HRESP_I, S_HRDATA_I,
        input  M_HREADY_O, M_HRESP_O, M_HRDATA_O, S_SEL_O
    );
endinterface

// File: rtl/ahb_mux_param.sv
// AHB-lite slave mux: one-hot HSEL decode, data-phase response mux, built-in
// default slave returning two-cycle ERROR for unmapped transfers, saturating error counter.
module ahb_mux_param #(
    parameter int NSLAVES = 7,
    parameter int SELW    = 3,
    parameter int DW      = 32,
    parameter int CNTW    = 8
) (
    input  logic                HCLK_I,
    input  logic                HRESET_I,
    ahb_mux_param_if.slave      bus,
    input  logic                ERR_CLR_I,
    output logic [CNTW-1:0]     ERR_CNT_O
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLV,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [SELW-1:0] SEL_MAX = SELW'(NSLAVES);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t            state_q, state_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              accept;
    logic              mapped;
    logic              s_rdy;
    logic              s_resp;
    logic [DW-1:0]     s_data;
    logic              hready;
    logic              hresp;
    logic [DW-1:0]     hrdata;
    logic [NSLAVES-1:0] hsel;
    logic              err_evt;

    assign accept = bus.M_HREADY_I & bus.M_HTRANS_I[1];
    assign mapped = (bus.M_SEL_I != '0) && (bus.M_SEL_I <= SEL_MAX);

    always_comb begin
        hsel = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            hsel[i] = (bus.M_SEL_I == SELW'(i + 1));
        end
    end

    // Only the slave owning the data phase is looked at; all others are masked out.
    always_comb begin
        s_rdy  = 1'b1;
        s_resp = 1'b0;
        s_data = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (sel_q == SELW'(i + 1)) begin
                s_rdy  = bus.S_HREADY_I[i];
                s_resp = bus.S_HRESP_I[i];
                s_data = bus.S_HRDATA_I[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge HCLK_I or posedge HRESET_I) begin
        if (HRESET_I) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hready  = 1'b1;
        hresp   = 1'b0;
        hrdata  = '0;

        case (state_q)
            ST_SLV: begin
                hready = s_rdy;
                hresp  = s_resp;
                hrdata = s_data;
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: ;
        endcase

        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (bus.M_HREADY_I) begin
            if (accept && mapped) begin
                state_d = ST_SLV;
                sel_d   = bus.M_SEL_I;
            end else if (accept) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign err_evt = hready & hresp;

    // A clear coinciding with an error event leaves that event counted.
    always_comb begin
        cnt_d = cnt_q;
        if (ERR_CLR_I) begin
            cnt_d = err_evt ? CNTW'(1) : '0;
        end else if (err_evt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    assign bus.M_HREADY_O = hready;
    assign bus.M_HRESP_O  = hresp;
    assign bus.M_HRDATA_O = hrdata;
    assign bus.S_SEL_O    = hsel;
    assign ERR_CNT_O      = cnt_q;

endmodule
